// File: rtl/gpio_mmio_if.sv
// rtl/gpio_mmio_if.sv - data-bus register port of the GPIO peripheral
interface gpio_mmio_if;
  logic [4:0]  addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output wen, output ren, output wdata, input rdata);
  modport slave  (input addr, input wen, input ren, input wdata, output rdata);
endinterface

// File: rtl/gpio_mmio.sv
// rtl/gpio_mmio.sv - GPIO peripheral: switches, debounced buttons with IRQ, LEDs, 7-seg scan
module gpio_mmio #(
  parameter int NUM_SW          = 16,
  parameter int NUM_BTN         = 5,
  parameter int NUM_LED         = 16,
  parameter int NUM_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REFRESH_CYCLES  = 100000
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_SW-1:0]     SW,
  input  logic [NUM_BTN-1:0]    BTN,
  input  logic [31:0]           writeback,
  gpio_mmio_if.slave            bus,
  output logic                  irq,
  output logic [NUM_LED-1:0]    LED,
  output logic [7:0]            SSEG_CA,
  output logic [NUM_DIGITS-1:0] SSEG_AN
);
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RFW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0] DAT_MASK = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << (4 * NUM_DIGITS)) - 32'd1);

  logic [NUM_SW-1:0]     sw_meta, sw_sync;
  logic [NUM_BTN-1:0]    btn_meta, btn_sync, btn_level, btn_edge, db_hit, edge_w1c;
  logic [DBW-1:0]        db_cnt [NUM_BTN];
  logic [31:0]           sseg_dat;
  logic [NUM_DIGITS-1:0] ctl_en, ctl_dp;
  logic                  ctl_mirror;
  logic [RFW-1:0]        refresh_cnt;
  logic [IW-1:0]         digit_idx;
  logic [31:0]           rd_val, src;
  logic [3:0]            nib;
  logic                  en_bit, dp_bit;
  logic [NUM_DIGITS-1:0] an_next;
  logic [7:0]            ca_next;
  logic                  addr_unused;

  assign addr_unused = ^bus.addr[1:0];
  assign edge_w1c = (bus.wen && bus.addr[4:2] == 3'd2) ? bus.wdata[NUM_BTN-1:0] : '0;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  // A button accepts its new level once its counter has seen a full stable window.
  always_comb begin
    db_hit = '0;
    for (int i = 0; i < NUM_BTN; i++)
      db_hit[i] = (btn_sync[i] != btn_level[i]) && (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1));
  end

  // Input synchronisers, debounce counters, sticky edge flags (set beats clear) and irq.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_level <= '0;
      btn_edge  <= '0;
      irq       <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sw_meta   <= SW;
      sw_sync   <= sw_meta;
      btn_meta  <= BTN;
      btn_sync  <= btn_meta;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_sync[i] == btn_level[i] || db_hit[i]) db_cnt[i] <= '0;
        else                                          db_cnt[i] <= db_cnt[i] + DBW'(1);
      end
      btn_level <= btn_level ^ db_hit;
      btn_edge  <= (btn_edge & ~edge_w1c) | (db_hit & btn_sync);
      irq       <= |btn_edge;
    end
  end

  // Read mux over current register state, so a same-cycle write returns the old value.
  always_comb begin
    rd_val = '0;
    case (bus.addr[4:2])
      3'd0: rd_val[NUM_SW-1:0]  = sw_sync;
      3'd1: rd_val[NUM_BTN-1:0] = btn_level;
      3'd2: rd_val[NUM_BTN-1:0] = btn_edge;
      3'd3: rd_val[NUM_LED-1:0] = LED;
      3'd4: rd_val              = sseg_dat;
      3'd5: begin
        rd_val[NUM_DIGITS-1:0]  = ctl_en;
        rd_val[8 +: NUM_DIGITS] = ctl_dp;
        rd_val[31]              = ctl_mirror;
      end
      default: rd_val = '0;
    endcase
  end

  // Writable registers and the registered read port.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      LED        <= '0;
      sseg_dat   <= '0;
      ctl_en     <= '0;
      ctl_dp     <= '0;
      ctl_mirror <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      if (bus.ren) bus.rdata <= rd_val;
      if (bus.wen) begin
        case (bus.addr[4:2])
          3'd3: LED <= bus.wdata[NUM_LED-1:0];
          3'd4: sseg_dat <= bus.wdata & DAT_MASK;
          3'd5: begin
            ctl_en     <= bus.wdata[NUM_DIGITS-1:0];
            ctl_dp     <= bus.wdata[8 +: NUM_DIGITS];
            ctl_mirror <= bus.wdata[31];
          end
          default: ;
        endcase
      end
    end
  end

  // Pattern for the digit currently selected by the scan index.
  always_comb begin
    src    = ctl_mirror ? writeback : sseg_dat;
    nib    = 4'd0;
    en_bit = 1'b0;
    dp_bit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IW'(k)) begin
        nib    = src[4*k +: 4];
        en_bit = ctl_en[k];
        dp_bit = ctl_dp[k];
      end
    end
    an_next = {NUM_DIGITS{1'b1}};
    ca_next = 8'hFF;
    if (en_bit) begin
      an_next = ~(NUM_DIGITS'(1) << digit_idx);
      ca_next = {~dp_bit, hex7(nib)};
    end
  end

  // Refresh timer steps the digit index; anodes and cathodes update in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      SSEG_AN     <= {NUM_DIGITS{1'b1}};
      SSEG_CA     <= 8'hFF;
    end else begin
      if (refresh_cnt == RFW'(REFRESH_CYCLES - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
      end else begin
        refresh_cnt <= refresh_cnt + RFW'(1);
      end
      SSEG_AN <= an_next;
      SSEG_CA <= ca_next;
    end
  end
endmodule
